hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage CPU. It sits beside the ID stage and drives the PC, IF/ID and ID/EX control-bubble mux. It detects load-use hazards and, optionally, branch-in-ID operand hazards, excluding x0 from all dependency checks. It adds a counted multi-cycle data-memory freeze FSM and a saturating stall-cycle performance counter.

## Interface

Parameters:
- REG_AW, 5, register address width.
- MEM_LAT, 1, data-memory latency in cycles; legal range 1..16. A value of 1 means no freeze.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  CPU run enable; when 0 the block is inert.
- rs1_i  in  REG_AW  rs1 of the instruction in IF/ID.
- rs2_i  in  REG_AW  rs2 of the instruction in IF/ID.
- branch_i  in  1  IF/ID instruction is a branch resolved in ID.
- id_ex_rd_i  in  REG_AW  ID/EX destination register.
- id_ex_memread_i  in  1  ID/EX instruction is a load.
- id_ex_regwrite_i  in  1  ID/EX instruction writes a register.
- ex_mem_rd_i  in  REG_AW  EX/MEM destination register.
- ex_mem_memread_i  in  1  EX/MEM instruction is a load.
- mem_access_i  in  1  EX/MEM instruction accesses data memory (load or store).
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID.
- bubble_o  out  1  zero ID/EX control signals (NOP insert).
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cycles_o  out  CNT_W  count of cycles with pc_stall_o=1.

## Operation

- Match function: match(r) = (r != 0) && (r == rs1_i || r == rs2_i).
- load_use = id_ex_memread_i && match(id_ex_rd_i).
- br_haz (macro-gated) = branch_i && ((id_ex_regwrite_i && match(id_ex_rd_i)) || (ex_mem_memread_i && match(ex_mem_rd_i))).
- FSM states:
  - IDLE: normal hazard evaluation.
  - WAIT: memory freeze in progress.
  - RELEASE: memory access completes.
- IDLE transitions:
  - mem_access_i=1 and MEM_LAT>1: freeze starts this cycle. Next state is WAIT, or RELEASE when MEM_LAT=2.
  - MEM_LAT=1: the block never leaves IDLE.
- WAIT transitions: freeze continues; leave for RELEASE once MEM_LAT-1 total freeze cycles have elapsed.
- RELEASE: freeze=0 and mem_access_i is ignored; the next state is always IDLE.
- While freezing (IDLE with access, or WAIT):
  - pipe_freeze_o=1, pc_stall_o=1, if_id_stall_o=1, bubble_o=0.
  - Hazard terms are not evaluated.
- When not freezing (IDLE with no access, or RELEASE): if load_use or br_haz, then pc_stall_o = if_id_stall_o = bubble_o = 1; otherwise all three are 0.
- Simultaneous hazard and new memory access in IDLE: the freeze wins. The hazard is re-evaluated in RELEASE.
- When start_i=0: all stall outputs are 0, the FSM is held in IDLE and the counter does not change.
- stall_cycles_o increments by 1 at each clock edge where pc_stall_o=1. It saturates at 2^CNT_W-1 and is cleared only by reset.

## Timing

- Stall outputs are combinational from the inputs and registered FSM state, with zero latency, the same as a classic HDU.
- FSM state and counter update on the rising edge of clk_i.
- Reset behaviour:
  - While rst_i=1, all outputs are 0.
  - The reset value of stall_cycles_o is 0 and the FSM resets to IDLE.
  - rst_i asserted in WAIT or RELEASE returns the FSM to IDLE the next cycle and aborts the freeze.
- Memory access first seen at cycle N, with MEM_LAT=L>1:
  - pipe_freeze_o=1 in cycles N..N+L-2.
  - Cycle N+L-1 is RELEASE.
  - Cycle N+L is IDLE.
- A load-use stall lasts exactly one cycle, because the bubble clears id_ex_memread_i.
- A branch hazard lasts 1 or 2 cycles: EX dependency, then MEM-load dependency.

## Configuration

- HDU_BRANCH_HAZARD_EN:
  - Defined: br_haz is included as specified.
  - Undefined: br_haz is constant 0, branch_i and ex_mem_* inputs are unused, and only load-use and memory-freeze stalls occur.

## Test plan

- Load-use, MEM_LAT=1:
  - Stimulus: id_ex_memread_i=1, id_ex_rd_i=5, rs2_i=5.
  - Response: pc_stall_o = if_id_stall_o = bubble_o = 1 for one cycle; stall_cycles_o 0→1.
- x0 exclusion:
  - Stimulus: id_ex_memread_i=1, id_ex_rd_i=0, rs1_i=0.
  - Response: all stall outputs 0 and the counter is unchanged.
- Memory freeze, MEM_LAT=4:
  - Stimulus: mem_access_i=1 held from cycle 10.
  - Response: pipe_freeze_o=1 in cycles 10–12, RELEASE at cycle 13, IDLE at 14; counter +3.
- Branch hazard (macro defined):
  - Stimulus: branch_i=1, rs1_i=7, id_ex_regwrite_i=1, id_ex_rd_i=7; next cycle ex_mem_memread_i=1, ex_mem_rd_i=7.
  - Response: bubble_o=1 for both cycles. With the macro undefined, no stall.
- Reset mid-freeze, MEM_LAT=8:
  - Stimulus: rst_i=1 at the 3rd freeze cycle.
  - Response: outputs 0 immediately, FSM IDLE, stall_cycles_o=0 the next cycle.
- Saturation, CNT_W=4:
  - Stimulus: 20 consecutive stall cycles.
  - Response: stall_cycles_o holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use / branch-in-ID stalls, multi-cycle memory freeze FSM, stall counter.
// Optional macro HDU_BRANCH_HAZARD_EN enables branch operand hazard detection in ID.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              branch_i,
    input  logic [REG_AW-1:0] id_ex_rd_i,
    input  logic              id_ex_memread_i,
    input  logic              id_ex_regwrite_i,
    input  logic [REG_AW-1:0] ex_mem_rd_i,
    input  logic              ex_mem_memread_i,
    input  logic              mem_access_i,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              bubble_o,
    output logic              pipe_freeze_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELEASE
    } state_e;

    localparam int unsigned     FW          = 5;
    localparam logic [FW-1:0]   FREEZE_LAST = FW'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [FW-1:0]     freezeCnt_q, freezeCnt_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    logic loadUse;
    logic brHaz;
    logic freeze;
    logic hazard;
    logic pcStall;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic regMatch(input logic [REG_AW-1:0] r,
                                      input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b);
        return (r != '0) && ((r == a) || (r == b));
    endfunction

    assign loadUse = id_ex_memread_i && regMatch(id_ex_rd_i, rs1_i, rs2_i);

`ifdef HDU_BRANCH_HAZARD_EN
    assign brHaz = branch_i &&
                   ((id_ex_regwrite_i && regMatch(id_ex_rd_i, rs1_i, rs2_i)) ||
                    (ex_mem_memread_i && regMatch(ex_mem_rd_i, rs1_i, rs2_i)));
`else
    logic unusedBranchInputs;
    assign unusedBranchInputs = ^{branch_i, id_ex_regwrite_i, ex_mem_rd_i, ex_mem_memread_i};
    assign brHaz = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        freezeCnt_d = freezeCnt_q;
        freeze      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((MEM_LAT > 1) && mem_access_i) begin
                    freeze      = 1'b1;
                    freezeCnt_d = FW'(1);
                    state_d     = (MEM_LAT == 2) ? RELEASE : WAIT;
                end
            end
            WAIT: begin
                freeze      = 1'b1;
                freezeCnt_d = freezeCnt_q + FW'(1);
                if ((freezeCnt_q + FW'(1)) == FREEZE_LAST) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A stopped CPU parks the FSM and masks every stall.
        if (!start_i) begin
            freeze  = 1'b0;
            state_d = IDLE;
        end
    end

    assign hazard  = start_i && !freeze && (loadUse || brHaz);
    assign pcStall = !rst_i && start_i && (freeze || hazard);

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (pcStall && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            freezeCnt_q <= '0;
            stallCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            freezeCnt_q <= freezeCnt_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign pc_stall_o     = pcStall;
    assign if_id_stall_o  = pcStall;
    assign bubble_o       = !rst_i && hazard;
    assign pipe_freeze_o  = !rst_i && freeze;
    assign stall_cycles_o = rst_i ? '0 : stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: three instances (MEM_LAT 1/4/8) checked against a cycle model.
// Honours HDU_BRANCH_HAZARD_EN to choose the expected branch-hazard behaviour.
module tb_hazard_ctrl_unit;

`ifdef HDU_BRANCH_HAZARD_EN
    localparam int BR = 1;
`else
    localparam int BR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, idExRd = '0, exMemRd = '0;
    logic       branch = 1'b0, idExMemread = 1'b0, idExRegwrite = 1'b0;
    logic       exMemMemread = 1'b0, memAccess = 1'b0;

    logic        pcW [3];
    logic        ifidW [3];
    logic        bubW [3];
    logic        fzW [3];
    logic [15:0] cntW [3];
    logic [3:0]  cnt4;

    int lat [3]    = '{1, 4, 8};
    int cntMax [3] = '{65535, 15, 65535};
    int busy [3]   = '{0, 0, 0};
    int cnt [3]    = '{0, 0, 0};

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rs1_i(rs1), .rs2_i(rs2),
        .branch_i(branch), .id_ex_rd_i(idExRd), .id_ex_memread_i(idExMemread),
        .id_ex_regwrite_i(idExRegwrite), .ex_mem_rd_i(exMemRd),
        .ex_mem_memread_i(exMemMemread), .mem_access_i(memAccess),
        .pc_stall_o(pcW[0]), .if_id_stall_o(ifidW[0]), .bubble_o(bubW[0]),
        .pipe_freeze_o(fzW[0]), .stall_cycles_o(cntW[0]));

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rs1_i(rs1), .rs2_i(rs2),
        .branch_i(branch), .id_ex_rd_i(idExRd), .id_ex_memread_i(idExMemread),
        .id_ex_regwrite_i(idExRegwrite), .ex_mem_rd_i(exMemRd),
        .ex_mem_memread_i(exMemMemread), .mem_access_i(memAccess),
        .pc_stall_o(pcW[1]), .if_id_stall_o(ifidW[1]), .bubble_o(bubW[1]),
        .pipe_freeze_o(fzW[1]), .stall_cycles_o(cnt4));
    assign cntW[1] = {12'b0, cnt4};

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(8), .CNT_W(16)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rs1_i(rs1), .rs2_i(rs2),
        .branch_i(branch), .id_ex_rd_i(idExRd), .id_ex_memread_i(idExMemread),
        .id_ex_regwrite_i(idExRegwrite), .ex_mem_rd_i(exMemRd),
        .ex_mem_memread_i(exMemMemread), .mem_access_i(memAccess),
        .pc_stall_o(pcW[2]), .if_id_stall_o(ifidW[2]), .bubble_o(bubW[2]),
        .pipe_freeze_o(fzW[2]), .stall_cycles_o(cntW[2]));

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit dep(input logic [4:0] r);
        return (r != 0) && (r == rs1 || r == rs2);
    endfunction

    // busy counts remaining occupied cycles: >1 still frozen, 1 is the release cycle.
    function automatic void modelOut(input int l, input int b, output bit fz, output bit pc, output bit bub);
        bit lu, bh;
        lu = idExMemread && dep(idExRd);
        bh = 1'b0;
        if (BR == 1)
            bh = branch && ((idExRegwrite && dep(idExRd)) || (exMemMemread && dep(exMemRd)));
        fz = 0; pc = 0; bub = 0;
        if (!rst && start) begin
            fz  = (b > 1) || (b == 0 && memAccess && l > 1);
            bub = !fz && (lu || bh);
            pc  = fz || bub;
        end
    endfunction

    always @(negedge clk) begin
        bit fz, pc, bub;
        for (int i = 0; i < 3; i++) begin
            modelOut(lat[i], busy[i], fz, pc, bub);
            checkOutput($sformatf("m%0d.pc_stall", i), int'(pcW[i]), int'(pc));
            checkOutput($sformatf("m%0d.if_id_stall", i), int'(ifidW[i]), int'(pc));
            checkOutput($sformatf("m%0d.bubble", i), int'(bubW[i]), int'(bub));
            checkOutput($sformatf("m%0d.freeze", i), int'(fzW[i]), int'(fz));
            checkOutput($sformatf("m%0d.stall_cycles", i), int'(cntW[i]), rst ? 0 : cnt[i]);
        end
    end

    always @(posedge clk) begin
        bit fz, pc, bub;
        for (int i = 0; i < 3; i++) begin
            modelOut(lat[i], busy[i], fz, pc, bub);
            if (rst) begin
                busy[i] = 0;
                cnt[i]  = 0;
            end else if (!start) begin
                busy[i] = 0;
            end else begin
                if (pc && cnt[i] < cntMax[i]) cnt[i]++;
                if (busy[i] > 0) busy[i]--;
                else if (memAccess && lat[i] > 1) busy[i] = lat[i] - 1;
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic br,
                                 input logic [4:0] exRd, input logic mr, input logic rw,
                                 input logic [4:0] memRd, input logic mmr, input logic acc);
        @(posedge clk);
        #1;
        rs1 = r1; rs2 = r2; branch = br; idExRd = exRd; idExMemread = mr;
        idExRegwrite = rw; exMemRd = memRd; exMemMemread = mmr; memAccess = acc;
    endtask

    initial begin
        int fzExp4 [6] = '{1, 1, 1, 0, 1, 1};
        int bubExp4 [6] = '{0, 0, 0, 1, 0, 0};

        applyStimulus(0, 5, 0, 5, 1, 0, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        checkOutput("rst_gates_stall", int'(pcW[0]), 0);
        checkOutput("rst_gates_bubble", int'(bubW[0]), 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        @(negedge clk);
        checkOutput("cnt_after_rst", int'(cntW[0]), 0);

        applyStimulus(0, 5, 0, 5, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("load_use_pc", int'(pcW[0]), 1);
        checkOutput("load_use_ifid", int'(ifidW[0]), 1);
        checkOutput("load_use_bubble", int'(bubW[0]), 1);
        checkOutput("load_use_nofreeze", int'(fzW[0]), 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("load_use_cnt", int'(cntW[0]), 1);

        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("x0_no_stall", int'(pcW[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("x0_cnt_same", int'(cntW[0]), 1);

        applyStimulus(0, 5, 0, 5, 1, 0, 0, 0, 0);
        start = 0;
        @(negedge clk);
        checkOutput("stopped_no_stall", int'(pcW[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        start = 1;
        @(negedge clk);
        checkOutput("stopped_cnt_same", int'(cntW[0]), 1);

        applyStimulus(7, 0, 1, 7, 0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("branch_ex_bubble", int'(bubW[0]), BR);
        applyStimulus(7, 0, 1, 3, 0, 0, 7, 1, 0);
        @(negedge clk);
        checkOutput("branch_mem_bubble", int'(bubW[0]), BR);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("branch_cnt", int'(cntW[0]), 1 + 2 * BR);

        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 5, 0, 5, 1, 0, 0, 0, 1);
            @(negedge clk);
            checkOutput($sformatf("freeze4_k%0d", k), int'(fzW[1]), fzExp4[k]);
            checkOutput($sformatf("bubble4_k%0d", k), int'(bubW[1]), bubExp4[k]);
            checkOutput($sformatf("freeze8_k%0d", k), int'(fzW[2]), 1);
            checkOutput($sformatf("freeze1_k%0d", k), int'(fzW[0]), 0);
        end

        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1;
        @(negedge clk);
        checkOutput("rst_mid_freeze_fz", int'(fzW[2]), 0);
        checkOutput("rst_mid_freeze_pc", int'(pcW[2]), 0);
        checkOutput("rst_mid_freeze_cnt", int'(cntW[2]), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        @(negedge clk);
        checkOutput("post_rst_idle", int'(fzW[2]), 0);
        checkOutput("post_rst_cnt", int'(cntW[2]), 0);

        for (int k = 0; k < 20; k++) applyStimulus(0, 5, 0, 5, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("sat_cnt4", int'(cntW[1]), 15);
        checkOutput("cnt16_20", int'(cntW[0]), 20);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
